instr_encoder: RTL and testbench

Sequential MIPS instruction encoder and instruction-memory loader. Accepts one instruction per handshake as an operation class plus operand fields and packs it into a 32-bit MIPS word using the same opcode map the main control unit decodes. Buffers the words in a small FIFO and writes them to instruction memory at consecutive word addresses. Used by the testbench/boot path to fill instruction memory before the datapath runs.

---
 rtl/instr_encoder.sv | 153 +++++++++++++++
 tb/tb_instr_encoder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// MIPS instruction encoder feeding a small FIFO that streams encoded words into
// instruction memory at consecutive word addresses.
module instr_encoder #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              err,
    output logic [15:0]       count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0]  OccFull  = OCC_W'(DEPTH);
    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

    localparam logic [1:0] FmtR   = 2'd0;
    localparam logic [1:0] FmtI   = 2'd1;
    localparam logic [1:0] FmtJ   = 2'd2;
    localparam logic [1:0] FmtBad = 2'd3;

    logic [31:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       count_q, count_d;
    logic              err_q, err_d;

    logic [5:0]  opc;
    logic [1:0]  fmt;
    logic [4:0]  rs_eff;
    logic [31:0] enc_word;
    logic        accept, push, pop;

    always_comb begin
        opc    = 6'b000000;
        fmt    = FmtI;
        rs_eff = in_rs;
        unique case (in_op)
            4'd0:    fmt = FmtR;
            4'd1:    opc = 6'b100011;
            4'd2:    opc = 6'b101011;
            4'd3:    opc = 6'b000100;
            4'd4:    opc = 6'b000101;
            4'd5:    begin opc = 6'b000010; fmt = FmtJ; end
            4'd6:    begin opc = 6'b000011; fmt = FmtJ; end
            4'd7:    opc = 6'b001000;
            4'd8:    opc = 6'b001100;
            4'd9:    opc = 6'b001101;
            4'd10:   opc = 6'b001110;
            4'd11:   opc = 6'b001010;
            4'd12:   opc = 6'b001011;
            4'd13:   begin opc = 6'b001111; rs_eff = 5'd0; end
            default: fmt = FmtBad;
        endcase
    end

    always_comb begin
        unique case (fmt)
            FmtR:    enc_word = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
            FmtI:    enc_word = {opc, rs_eff, in_rt, in_imm};
            FmtJ:    enc_word = {opc, in_target};
            default: enc_word = 32'd0;
        endcase
    end

    assign in_ready = (occ_q < OccFull) && !flush && !reset;
    assign accept   = in_valid && in_ready;
    assign push     = accept && (fmt != FmtBad);
    assign wr_valid = (occ_q != '0);
    assign pop      = wr_valid && wr_ready;

    always_comb begin
        occ_d    = occ_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        addr_d   = addr_q;
        count_d  = count_q;
        err_d    = err_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            addr_d   = addr_q + ADDR_W'(4);
            if (count_q != 16'hFFFF) begin
                count_d = count_q + 16'd1;
            end
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (accept && (fmt == FmtBad)) begin
            err_d = 1'b1;
        end
        if (push && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - OCC_W'(1);
        end
        // A write completing during flush still advances address and count.
        if (flush) begin
            occ_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            occ_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            addr_q   <= BaseAddr;
            count_q  <= 16'd0;
            err_q    <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 32'd0;
            end
        end else begin
            occ_q    <= occ_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            err_q    <= err_d;
            if (push) begin
                mem_q[wr_ptr_q] <= enc_word;
            end
        end
    end

    assign wr_addr = addr_q;
    assign wr_data = mem_q[rd_ptr_q];
    assign err     = err_q;
    assign count   = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, backpressure, illegal ops,
// address wrap, flush and mid-stream reset.
module tb_instr_encoder;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        err;
    logic [15:0] count;

    int errors = 0;
    int checks = 0;

    logic [31:0] mon_data[$];
    logic [7:0]  mon_addr[$];
    logic [31:0] exp_data[$];
    logic [7:0]  exp_addr[$];

    instr_encoder #(
        .DEPTH     (4),
        .ADDR_W    (8),
        .BASE_ADDR (0)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_shamt  (in_shamt),
        .in_funct  (in_funct),
        .in_imm    (in_imm),
        .in_target (in_target),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .err       (err),
        .count     (count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Inputs only change just after posedge, so a negedge sample sees the handshake.
    always @(negedge clock) begin
        if (!reset && wr_valid && wr_ready) begin
            mon_data.push_back(wr_data);
            mon_addr.push_back(wr_addr);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mon_data.delete();
        mon_addr.delete();
        exp_data.delete();
        exp_addr.delete();
    endtask

    task automatic expect_wr(input logic [7:0] a, input logic [31:0] d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    task automatic compare_writes(input string tag);
        check_eq({tag, " n"}, 32'(mon_data.size()), 32'(exp_data.size()));
        for (int i = 0; i < exp_data.size(); i++) begin
            check_eq($sformatf("%s addr[%0d]", tag, i), {24'd0, mon_addr[i]}, {24'd0, exp_addr[i]});
            check_eq($sformatf("%s data[%0d]", tag, i), mon_data[i], exp_data[i]);
        end
        mon_data.delete();
        mon_addr.delete();
        exp_data.delete();
        exp_addr.delete();
    endtask

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm,
                        input logic [25:0] target);
        in_op     = op;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_shamt  = 5'd0;
        in_funct  = funct;
        in_imm    = imm;
        in_target = target;
        in_valid  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (in_ready) begin
                tick();
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        check_eq("send timeout", 32'd0, 32'd1);
    endtask

    task automatic send_addi(input logic [4:0] rt, input logic [15:0] imm);
        send(4'd7, 5'd0, rt, 5'd0, 6'd0, imm, 26'd0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; wr_ready = 1'b0;
        in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
        in_funct = '0; in_imm = '0; in_target = '0;

        @(negedge clock);
        check_eq("rst in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("rst wr_valid", {31'd0, wr_valid}, 32'd0);
        check_eq("rst wr_addr", {24'd0, wr_addr}, 32'd0);
        check_eq("rst wr_data", wr_data, 32'd0);
        check_eq("rst err", {31'd0, err}, 32'd0);
        check_eq("rst count", {16'd0, count}, 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clock);
        check_eq("post rst in_ready", {31'd0, in_ready}, 32'd1);

        // Single addi, one-cycle latency.
        tick();
        wr_ready = 1'b1;
        send_addi(5'd8, 16'd5);
        @(negedge clock);
        check_eq("addi wr_valid", {31'd0, wr_valid}, 32'd1);
        check_eq("addi wr_addr", {24'd0, wr_addr}, 32'd0);
        check_eq("addi wr_data", wr_data, 32'h20080005);
        tick();
        @(negedge clock);
        check_eq("addi count", {16'd0, count}, 32'd1);
        check_eq("addi drained", {31'd0, wr_valid}, 32'd0);

        // Mixed stream plus lui with nonzero rs.
        tick();
        do_reset();
        send(4'd1, 5'd29, 5'd8, 5'd0, 6'd0, 16'd4, 26'd0);
        send(4'd0, 5'd9, 5'd10, 5'd8, 6'h20, 16'd0, 26'd0);
        send(4'd5, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0100000);
        send(4'd6, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000010);
        send(4'd13, 5'd5, 5'd1, 5'd0, 6'd0, 16'h1001, 26'd0);
        repeat (4) tick();
        expect_wr(8'h00, 32'h8FA80004);
        expect_wr(8'h04, 32'h012A4020);
        expect_wr(8'h08, 32'h08100000);
        expect_wr(8'h0C, 32'h0C000010);
        expect_wr(8'h10, 32'h3C011001);
        compare_writes("stream");
        check_eq("stream count", {16'd0, count}, 32'd5);

        // Backpressure: four fill the FIFO, the fifth waits.
        do_reset();
        wr_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            send_addi(5'(k), 16'(k));
        end
        in_op = 4'd7; in_rs = 5'd0; in_rt = 5'd5; in_imm = 16'd5; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check_eq("full in_ready", {31'd0, in_ready}, 32'd0);
            check_eq("stall wr_data", wr_data, 32'h20010001);
            check_eq("stall wr_addr", {24'd0, wr_addr}, 32'd0);
            tick();
        end
        wr_ready = 1'b1;
        send_addi(5'd5, 16'd5);
        repeat (8) tick();
        for (int k = 1; k <= 5; k++) begin
            expect_wr(8'((k - 1) * 4), {6'b001000, 5'd0, 5'(k), 16'(k)});
        end
        compare_writes("bp");

        // Illegal op between two addi.
        do_reset();
        send_addi(5'd8, 16'd5);
        send(4'd15, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
        @(negedge clock);
        check_eq("illegal err", {31'd0, err}, 32'd1);
        tick();
        send_addi(5'd9, 16'd6);
        repeat (3) tick();
        expect_wr(8'h00, 32'h20080005);
        expect_wr(8'h04, 32'h20090006);
        compare_writes("illegal");
        check_eq("illegal err sticky", {31'd0, err}, 32'd1);

        // Address wrap after 64 words.
        do_reset();
        for (int k = 0; k < 65; k++) begin
            send_addi(5'd0, 16'(k));
        end
        repeat (3) tick();
        check_eq("wrap n", 32'(mon_addr.size()), 32'd65);
        check_eq("wrap addr63", {24'd0, mon_addr[63]}, 32'h000000FC);
        check_eq("wrap addr64", {24'd0, mon_addr[64]}, 32'd0);
        check_eq("wrap data64", mon_data[64], 32'h20000040);
        check_eq("wrap count", {16'd0, count}, 32'd65);
        mon_data.delete();
        mon_addr.delete();

        // Flush three queued words; address and count persist.
        wr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            send_addi(5'd3, 16'(k));
        end
        @(negedge clock);
        check_eq("preflush wr_valid", {31'd0, wr_valid}, 32'd1);
        tick();
        flush = 1'b1;
        @(negedge clock);
        check_eq("flush in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        @(negedge clock);
        check_eq("flush wr_valid", {31'd0, wr_valid}, 32'd0);
        check_eq("flush wr_addr", {24'd0, wr_addr}, 32'd4);
        check_eq("flush count", {16'd0, count}, 32'd65);
        tick();
        wr_ready = 1'b1;
        send_addi(5'd7, 16'h0077);
        repeat (3) tick();
        expect_wr(8'h04, 32'h20070077);
        compare_writes("postflush");
        check_eq("postflush count", {16'd0, count}, 32'd66);

        // Reset mid-stream discards buffered words.
        wr_ready = 1'b0;
        send_addi(5'd1, 16'd1);
        send_addi(5'd2, 16'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        check_eq("midrst wr_valid", {31'd0, wr_valid}, 32'd0);
        check_eq("midrst wr_addr", {24'd0, wr_addr}, 32'd0);
        check_eq("midrst count", {16'd0, count}, 32'd0);
        check_eq("midrst wr_data", wr_data, 32'd0);
        check_eq("midrst in_ready", {31'd0, in_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
